// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a strobe-driven tag memory.
// Each transaction walks IDLE -> ISSUE -> RELEASE -> DONE. Every output comes
// straight from a flop, and the memory strobes are held for HOLD_CYCLES.
module mem_arbiter #(
   parameter int unsigned HOLD_CYCLES = 1
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       req0,
   input  logic       req1,
   input  logic       we0,
   input  logic       we1,
   input  logic [2:0] addr0,
   input  logic [2:0] addr1,
   input  logic [2:0] wdata0,
   input  logic [2:0] wdata1,
   output logic       gnt0,
   output logic       gnt1,
   output logic       done0,
   output logic       done1,
   output logic [2:0] rdata,
   output logic [2:0] mem_endereco,
   output logic       mem_read,
   output logic [2:0] mem_enderecoWB,
   output logic [2:0] mem_dadoWB,
   output logic       mem_WB,
   input  logic [2:0] mem_out
);

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StRelease,
      StDone
   } state_e;

   // Strobe cycles left after the current one; loaded on grant.
   localparam logic [1:0] HoldLast = 2'(HOLD_CYCLES - 1);

   state_e     state_q, state_d;
   logic       last_q, last_d;        // 1: requester 1 was served most recently
   logic       owner_q, owner_d;      // requester owning the current transaction
   logic       we_q, we_d;
   logic [2:0] addr_q, addr_d;
   logic [2:0] wdata_q, wdata_d;
   logic [1:0] cnt_q, cnt_d;
   logic       gnt0_q, gnt0_d;
   logic       gnt1_q, gnt1_d;
   logic       done0_q, done0_d;
   logic       done1_q, done1_d;
   logic [2:0] rdata_q, rdata_d;
   logic       mem_read_q, mem_read_d;
   logic       mem_wb_q, mem_wb_d;

   logic       win;
   logic       win_we;

   // Next-state, arbitration and registered-output computation.
   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      owner_d    = owner_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      cnt_d      = cnt_q;
      gnt0_d     = gnt0_q;
      gnt1_d     = gnt1_q;
      rdata_d    = rdata_q;
      done0_d    = 1'b0;
      done1_d    = 1'b0;
      mem_read_d = 1'b0;
      mem_wb_d   = 1'b0;
      // On a tie the requester not served last wins; otherwise the lone requester.
      win        = (req0 && req1) ? ~last_q : req1;
      win_we     = win ? we1 : we0;

      unique case (state_q)
         StIdle: begin
            if (req0 || req1) begin
               owner_d    = win;
               last_d     = win;
               we_d       = win_we;
               addr_d     = win ? addr1 : addr0;
               wdata_d    = win ? wdata1 : wdata0;
               cnt_d      = HoldLast;
               gnt0_d     = ~win;
               gnt1_d     = win;
               mem_read_d = ~win_we;
               mem_wb_d   = win_we;
               state_d    = StIssue;
            end
         end
         StIssue: begin
            if (cnt_q == 2'd0) begin
               state_d = StRelease;
            end else begin
               cnt_d      = cnt_q - 2'd1;
               mem_read_d = ~we_q;
               mem_wb_d   = we_q;
            end
         end
         StRelease: begin
            // Memory has had a full strobe-low cycle; its read data is settled.
            if (!we_q) begin
               rdata_d = mem_out;
            end
            done0_d = ~owner_q;
            done1_d = owner_q;
            state_d = StDone;
         end
         StDone: begin
            gnt0_d  = 1'b0;
            gnt1_d  = 1'b0;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and output registers; reset drops every output at once.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         last_q     <= 1'b1;
         owner_q    <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= 3'd0;
         wdata_q    <= 3'd0;
         cnt_q      <= 2'd0;
         gnt0_q     <= 1'b0;
         gnt1_q     <= 1'b0;
         done0_q    <= 1'b0;
         done1_q    <= 1'b0;
         rdata_q    <= 3'd0;
         mem_read_q <= 1'b0;
         mem_wb_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         owner_q    <= owner_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         cnt_q      <= cnt_d;
         gnt0_q     <= gnt0_d;
         gnt1_q     <= gnt1_d;
         done0_q    <= done0_d;
         done1_q    <= done1_d;
         rdata_q    <= rdata_d;
         mem_read_q <= mem_read_d;
         mem_wb_q   <= mem_wb_d;
      end
   end

   // Address and data come from the latched request, so they stay frozen
   // from grant until the next grant regardless of requester input activity.
   assign gnt0           = gnt0_q;
   assign gnt1           = gnt1_q;
   assign done0          = done0_q;
   assign done1          = done1_q;
   assign rdata          = rdata_q;
   assign mem_endereco   = addr_q;
   assign mem_read       = mem_read_q;
   assign mem_enderecoWB = addr_q;
   assign mem_dadoWB     = wdata_q;
   assign mem_WB         = mem_wb_q;

endmodule
